// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and frame constants for the FIFO-draining 8N1 UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;

    assign bit_tick = en && (baud_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            baud_cnt <= '0;
        end else if (en) begin
            baud_cnt <= bit_tick ? '0 : baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte at a time from the FIFO read port and shifts it out as an 8N1 frame.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_t              state, state_nxt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   bit_tick;
    logic                   baud_en;
    logic                   baud_clr;

    baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clr),
        .en       (baud_en),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    shift_reg <= fifo_data;
                    bit_cnt   <= '0;
                end
                DATA: begin
                    // bit_cnt rolls 7->0 on the same edge that enters STOP
                    if (bit_tick) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        tx         = 1'b1;
        fifo_rd_en = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        baud_en    = 1'b0;
        baud_clr   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) begin
                    fifo_rd_en = !reset;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                baud_clr  = 1'b1;
                state_nxt = START;
            end
            START: begin
                tx      = 1'b0;
                baud_en = 1'b1;
                if (bit_tick) state_nxt = DATA;
            end
            DATA: begin
                tx      = shift_reg[0];
                baud_en = 1'b1;
                if (bit_tick && bit_cnt == LAST_BIT) state_nxt = STOP;
            end
            STOP: begin
                baud_en    = 1'b1;
                frame_done = bit_tick;
                if (bit_tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
